// File: rtl/fp_sqrt_radix2_core_pkg.sv
// Shared types for the radix-2 digit-recurrence square-root engine.
package fp_sqrt_radix2_core_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } sqrt_state_t;

endpackage : fp_sqrt_radix2_core_pkg

// File: rtl/fp_sqrt_radix2_core.sv
// Iterative unsigned square root: result = floor(sqrt(radicand * 2^DATA_WIDTH)),
// one root bit per cycle, with exact remainder.
module fp_sqrt_radix2_core
  import fp_sqrt_radix2_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] radicand,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH:0]   remainder,
  output logic                  busy
);

  localparam int unsigned W      = DATA_WIDTH;
  localparam int unsigned OP_W   = 2 * W;
  localparam int unsigned PREM_W = W + 1;
  localparam int unsigned T_W    = W + 3;
  localparam int unsigned CNT_W  = $clog2(W);

  sqrt_state_t         state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [W-1:0]        root_q, root_d;
  logic [PREM_W-1:0]   prem_q, prem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [T_W-1:0]      t_c;
  logic [T_W-1:0]      trial_c;
  logic [T_W-1:0]      diff_c;
  logic                ge_c;

  // One recurrence step: bring down two radicand bits and try digit 1.
  always_comb begin
    t_c     = {prem_q, op_q[OP_W-1 -: 2]};
    trial_c = {1'b0, root_q, 2'b01};
    ge_c    = (t_c >= trial_c);
    diff_c  = t_c - trial_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      root_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      root_q  <= root_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // start has priority in both states so a new request aborts a running one.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    root_d  = root_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (start) begin
      state_d = ITER;
      op_d    = {radicand, W'(0)};
      root_d  = '0;
      prem_d  = '0;
      cnt_d   = CNT_W'(W - 1);
    end else if (state_q == ITER) begin
      op_d   = {op_q[OP_W-3:0], 2'b00};
      root_d = {root_q[W-2:0], ge_c};
      prem_d = ge_c ? PREM_W'(diff_c) : PREM_W'(t_c);
      if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    busy_d = (state_d == ITER) || done_d;
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign result    = root_q;
  assign remainder = prem_q;

endmodule : fp_sqrt_radix2_core

// File: doc/fp_sqrt_radix2_core.md
# fp_sqrt_radix2_core

Iterative radix-2 digit-recurrence unsigned square-root engine. It is the responder side of `unsigned_sqrt_interface` and serves the FP square-root unit, which presents a normalized, pre-aligned mantissa radicand and consumes the root and remainder. The engine computes `result = floor(sqrt(radicand * 2^DATA_WIDTH))` and the exact remainder, one root bit per cycle. It does no rounding or exception handling; the FP writeback path does those.

## Interface
- `DATA_WIDTH`, default 28 (`FRAC_WIDTH+5` for single precision). Radicand and root width; must be ≥ 4.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high (already decided).
- `start` in 1: single-cycle request pulse; `radicand` is sampled in the same cycle.
- `radicand` in DATA_WIDTH: unsigned operand. The caller guarantees that at least one of the two MSBs is set.
- `done` out 1: one-cycle completion pulse.
- `result` out DATA_WIDTH: root. Valid from `done` until the next `start`.
- `remainder` out DATA_WIDTH+1: `radicand*2^DATA_WIDTH - result^2`. Valid under the same rule as `result`.
- `busy` out 1: high from the cycle after `start` through the cycle `done` is high.

## Operation
- States are IDLE and ITER, plus a `done` flag register.
- IDLE + `start`:
  - Load the operand shift register (2·DATA_WIDTH bits) with `{radicand, DATA_WIDTH'0}`.
  - Clear `root` and the partial remainder `prem`.
  - Set the iteration counter to DATA_WIDTH-1.
  - Go to ITER.
- ITER, each cycle:
  - `t = {prem, op[2W-1:2W-2]}`.
  - `trial = {root, 2'b01}`.
  - If `t ≥ trial`: `prem = t - trial`, `root = {root,1}`. Otherwise `prem = t`, `root = {root,0}`.
  - Shift `op` left by 2.
  - On counter = 0: go to IDLE and set `done` for one cycle. Otherwise decrement the counter.
- Widths:
  - `prem` is DATA_WIDTH+1 bits, because the remainder is ≤ 2·root.
  - `t` and `trial` are DATA_WIDTH+3 bits.
  - Subtraction never underflows because it is guarded by the compare.
- `result = root`; `remainder = prem`. Both hold their values in IDLE.
- Given the MSB guarantee on `radicand`, `result[DATA_WIDTH-1]` is always 1.
- `start` while in ITER: abort the current operation and reload from the new radicand. No `done` is produced for the aborted operation.
- `start` in the cycle `done` is high: `done` still pulses that cycle and the new operation starts normally. `result` and `remainder` then begin changing the next cycle, so the consumer must capture them on `done`.
- Reset values: state IDLE, `done`=0, `busy`=0, `result`=0, `remainder`=0, counter=0.
- Reset while in ITER drops the operation and produces no `done`.

## Timing
- `start` high in cycle 0. Iterations occur at the ends of cycles 1..DATA_WIDTH. `done` is high in cycle DATA_WIDTH+1.
- Latency is DATA_WIDTH+1 cycles. For single precision (DATA_WIDTH=28), latency is 29.
- Throughput: a new `start` may be issued in the `done` cycle. Back-to-back operations therefore space DATA_WIDTH+1 cycles apart.
- `done` is driven directly from a flop. `result` and `remainder` are driven directly from registers.
- Critical path: one DATA_WIDTH+3-bit compare/subtract plus a mux.

## Structure
- Standalone module. No sub-module is needed; the datapath and control are small.
- The `unsigned_sqrt_interface` definition, with `DATA_WIDTH` and a `remainder` of DATA_WIDTH+1 bits, lives alongside the other FPU interfaces.
- The instantiator binds this module's ports to the interface's responder side.
- Shared constants (`FRAC_WIDTH`, `GRS_WIDTH`) come from `fpu_types`. The core itself uses only `DATA_WIDTH`, with no package dependency.

## Test plan
All scenarios use DATA_WIDTH=28.
- Exact root: radicand 0x4000000 → `done` exactly 29 cycles after `start`, `result`=0x8000000, `remainder`=0.
- Exact odd-pattern root: radicand 0x9000000 → `result`=0xC000000, `remainder`=0.
- Remainder needing the extra bit: radicand 0x4000001 → `result`=0x8000000, `remainder`=0x10000000.
- Maximum input: radicand 0xFFFFFFF → `result`=0xFFFFFFF, `remainder`=0xFFFFFFF. Then `start` in the `done` cycle with 0x4000000 → second `done` 29 cycles later with the correct values.
- Abort and reset:
  - `start` 0x9000000, then `start` 0x4000000 ten cycles later → a single `done`, 29 cycles after the second `start`, with `result`=0x8000000.
  - Separately, asserting `rst` mid-ITER → no `done`, and all outputs are 0 the next cycle.
- Random self-check: 10k random radicands with one of the two top bits set, random `start` gaps including zero gap after `done`. Check `result^2 + remainder == radicand<<28` and `remainder ≤ 2·result` for each.
